// File: rtl/counter_ctrl_pkg.sv
// Shared opcodes, state encoding and mode constants for the counter_ctrl timer.
package counter_ctrl_pkg;

   localparam logic [1:0] OP_STOP           = 2'b00;
   localparam logic [1:0] OP_START_ONESHOT  = 2'b01;
   localparam logic [1:0] OP_START_PERIODIC = 2'b10;
   localparam logic [1:0] OP_CLEAR          = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

   function automatic logic is_start(input logic [1:0] op);
      return (op == OP_START_ONESHOT) || (op == OP_START_PERIODIC);
   endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Prescale counter: asserts tick on every enabled cycle where pre matches div,
// so ticks occur once every div+1 enabled cycles.
module counter_prescaler #(
   parameter int PRE_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [PRE_W-1:0] div,
   output logic             tick
);

   logic [PRE_W-1:0] pre;

   assign tick = en && (pre == div);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre <= '0;
      end else if (clr) begin
         pre <= '0;
      end else if (en) begin
         if (pre == div) pre <= '0;
         else            pre <= pre + PRE_W'(1);
      end
   end

endmodule

// File: rtl/counter_ctrl.sv
// Programmable one-shot / periodic timer built around a 4-bit count register,
// configured through a valid/ready command port.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | stopped; count, periods and config held (or cleared by CLEAR)
// LOAD  | one-cycle settle after START; commands are not accepted
// RUN   | prescaler running, count advances on each tick
// DONE  | one-shot reached its limit; count and periods held
module counter_ctrl
   import counter_ctrl_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int PRE_W = 8,
   parameter int PER_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_limit,
   input  logic [PRE_W-1:0] cmd_div,
   output logic [WIDTH-1:0] count,
   output logic             tc_pulse,
   output logic [PER_W-1:0] periods,
   output logic             busy,
   output logic             done
);

   state_t           state;
   logic [WIDTH-1:0] limit_q;
   logic [PRE_W-1:0] div_q;
   logic             mode_q;

   logic cmd_fire;
   logic start_fire;
   logic run_en;
   logic tick;

   assign cmd_ready  = (state != ST_LOAD);
   assign cmd_fire   = cmd_valid && cmd_ready;
   assign start_fire = cmd_fire && is_start(cmd_op);
   // An accepted command outranks a tick landing on the same edge.
   assign run_en     = (state == ST_RUN) && !cmd_fire;

   counter_prescaler #(
      .PRE_W (PRE_W)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .clr  (start_fire),
      .en   (run_en),
      .div  (div_q),
      .tick (tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         count    <= '0;
         periods  <= '0;
         tc_pulse <= 1'b0;
         limit_q  <= '0;
         div_q    <= '0;
         mode_q   <= MODE_ONESHOT;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         tc_pulse <= 1'b0;
         if (cmd_fire) begin
            case (cmd_op)
               OP_START_ONESHOT, OP_START_PERIODIC: begin
                  limit_q <= cmd_limit;
                  div_q   <= cmd_div;
                  mode_q  <= (cmd_op == OP_START_PERIODIC) ? MODE_PERIODIC : MODE_ONESHOT;
                  count   <= '0;
                  periods <= '0;
                  state   <= ST_LOAD;
                  busy    <= 1'b1;
                  done    <= 1'b0;
               end
               OP_CLEAR: begin
                  count   <= '0;
                  periods <= '0;
                  state   <= ST_IDLE;
                  busy    <= 1'b0;
                  done    <= 1'b0;
               end
               default: begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b0;
               end
            endcase
         end else begin
            case (state)
               ST_LOAD: begin
                  state <= ST_RUN;
                  busy  <= 1'b1;
                  done  <= 1'b0;
               end
               ST_RUN: begin
                  if (tick) begin
                     if (count == limit_q) begin
                        tc_pulse <= 1'b1;
                        if (periods != {PER_W{1'b1}}) periods <= periods + PER_W'(1);
                        if (mode_q == MODE_PERIODIC) begin
                           count <= '0;
                        end else begin
                           state <= ST_DONE;
                           busy  <= 1'b0;
                           done  <= 1'b1;
                        end
                     end else begin
                        count <= count + WIDTH'(1);
                     end
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed self-checking bench for counter_ctrl.
module tb_counter_ctrl;
   import counter_ctrl_pkg::*;

   logic       clk;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [3:0] cmd_limit;
   logic [7:0] cmd_div;
   logic [3:0] count;
   logic       tc_pulse;
   logic [7:0] periods;
   logic       busy;
   logic       done;

   int n_tests = 0;
   int n_fail  = 0;

   counter_ctrl #(
      .WIDTH (4),
      .PRE_W (8),
      .PER_W (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_limit (cmd_limit),
      .cmd_div   (cmd_div),
      .count     (count),
      .tc_pulse  (tc_pulse),
      .periods   (periods),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Called at a negedge: drive one command for exactly one rising edge.
   task automatic send(input logic [1:0] op, input logic [3:0] lim, input logic [7:0] dv);
      cmd_op    = op;
      cmd_limit = lim;
      cmd_div   = dv;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   initial begin
      int exp_cnt[7];
      int bad;
      exp_cnt = '{0, 0, 1, 1, 2, 2, 0};

      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = OP_STOP;
      cmd_limit = '0;
      cmd_div   = '0;
      @(negedge clk);
      @(negedge clk);
      check("rst_count", count, 0);
      check("rst_ready", cmd_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_tc", tc_pulse, 0);
      check("rst_periods", periods, 0);
      rst = 1'b0;
      @(negedge clk);

      // One-shot, limit 3, div 0
      send(OP_START_ONESHOT, 4'd3, 8'd0);
      check("os3_load_ready", cmd_ready, 0);
      check("os3_load_busy", busy, 1);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         check($sformatf("os3_count_e%0d", k), count, k - 1);
         check($sformatf("os3_tc_e%0d", k), tc_pulse, 0);
      end
      @(negedge clk);
      check("os3_tc_e5", tc_pulse, 1);
      check("os3_done_e5", done, 1);
      check("os3_count_e5", count, 3);
      check("os3_periods_e5", periods, 1);
      check("os3_busy_e5", busy, 0);
      @(negedge clk);
      check("os3_tc_e6", tc_pulse, 0);
      check("os3_done_e6", done, 1);
      check("os3_count_e6", count, 3);

      // One-shot, limit 0, started from DONE, then CLEAR
      send(OP_START_ONESHOT, 4'd0, 8'd0);
      check("os0_done_drop", done, 0);
      check("os0_busy", busy, 1);
      check("os0_periods_reset", periods, 0);
      @(negedge clk);
      check("os0_tc_e1", tc_pulse, 0);
      @(negedge clk);
      check("os0_tc_e2", tc_pulse, 1);
      check("os0_done_e2", done, 1);
      check("os0_count_e2", count, 0);
      check("os0_periods_e2", periods, 1);
      send(OP_CLEAR, 4'd0, 8'd0);
      check("clr_count", count, 0);
      check("clr_periods", periods, 0);
      check("clr_done", done, 0);
      check("clr_busy", busy, 0);
      check("clr_ready", cmd_ready, 1);

      // Periodic, limit 2, div 1, run to saturation
      send(OP_START_PERIODIC, 4'd2, 8'd1);
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         check($sformatf("per_count_e%0d", k), count, exp_cnt[k-1]);
         check($sformatf("per_tc_e%0d", k), tc_pulse, (k == 7) ? 1 : 0);
      end
      check("per_periods_1", periods, 1);
      bad = 0;
      for (int j = 1; j <= 6 * 299; j++) begin
         @(negedge clk);
         if (tc_pulse !== ((j % 6) == 0)) bad++;
         if (count > 4'd2) bad++;
         if (j == 24) check("per_periods_5", periods, 5);
      end
      check("per_spacing_errs", bad, 0);
      check("per_periods_sat", periods, 255);
      check("per_busy", busy, 1);
      send(OP_CLEAR, 4'd0, 8'd0);
      check("per_clr_periods", periods, 0);

      // Handshake with cmd_valid held across LOAD
      cmd_op    = OP_START_PERIODIC;
      cmd_limit = 4'd5;
      cmd_div   = 8'd0;
      cmd_valid = 1'b1;
      @(negedge clk);
      check("hs_load_ready", cmd_ready, 0);
      check("hs_load_busy", busy, 1);
      @(negedge clk);
      check("hs_run_ready", cmd_ready, 1);
      cmd_limit = 4'd7;
      @(negedge clk);
      check("hs_second_load_ready", cmd_ready, 0);
      check("hs_second_count", count, 0);
      cmd_valid = 1'b0;
      @(negedge clk);
      check("hs_run2_count_e1", count, 0);
      @(negedge clk);
      check("hs_run2_count_e2", count, 1);

      // STOP colliding with the terminal tick, periodic limit 1
      send(OP_START_PERIODIC, 4'd1, 8'd0);
      @(negedge clk);
      check("col_count_e1", count, 0);
      @(negedge clk);
      check("col_count_e2", count, 1);
      @(negedge clk);
      check("col_tc_e3", tc_pulse, 1);
      check("col_count_e3", count, 0);
      check("col_periods_e3", periods, 1);
      @(negedge clk);
      check("col_count_e4", count, 1);
      send(OP_STOP, 4'd0, 8'd0);
      check("col_tc", tc_pulse, 0);
      check("col_count", count, 1);
      check("col_periods", periods, 1);
      check("col_busy", busy, 0);
      check("col_done", done, 0);
      check("col_ready", cmd_ready, 1);
      @(negedge clk);
      check("col_tc_after", tc_pulse, 0);
      check("col_count_after", count, 1);

      // Asynchronous reset in the middle of RUN
      send(OP_START_PERIODIC, 4'd5, 8'd0);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check("mrst_count_pre", count, 2);
      #2 rst = 1'b1;
      #1;
      check("mrst_count", count, 0);
      check("mrst_busy", busy, 0);
      check("mrst_ready", cmd_ready, 1);
      check("mrst_tc", tc_pulse, 0);
      check("mrst_periods", periods, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("mrst_count_after", count, 0);
      check("mrst_busy_after", busy, 0);
      check("mrst_tc_after", tc_pulse, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
Sequencer for the free-running 4-bit counter datapath. It turns it into a programmable timer with one-shot and periodic modes, a prescaler, a terminal-count event and a saturating period tally. Configuration arrives over a valid/ready command port from the SoC-side logic. Internally it owns the count register, so it replaces a bare counter where software-controlled timing is needed.

Parameters:
WIDTH, 4, count / terminal-limit width
PRE_W, 8, prescaler divide-field width
PER_W, 8, period tally width (saturating)

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge
cmd_op  in  2  00 STOP, 01 START_ONESHOT, 10 START_PERIODIC, 11 CLEAR
cmd_limit  in  WIDTH  terminal count for START ops
cmd_div  in  PRE_W  prescale; one tick every cmd_div+1 RUN cycles
count  out  WIDTH  current count (registered)
tc_pulse  out  1  one-cycle pulse at terminal count (registered)
periods  out  PER_W  terminal-count events since last START/CLEAR, saturates at all-ones
busy  out  1  state is LOAD or RUN
done  out  1  state is DONE (one-shot finished)

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; count=0, pre=0, periods=0, tc_pulse=0.
  - limit_q, div_q and mode_q are cleared to 0.
  - Resulting outputs: cmd_ready=1, busy=0, done=0.
  - Reset mid-RUN aborts immediately with no tc_pulse.
- States: IDLE, LOAD, RUN, DONE.
- cmd_ready = (state != LOAD), combinational from state only; it never depends on cmd_valid.
- Command accepted at edge E0, from IDLE, RUN or DONE:
  - START_*: latch limit_q, div_q and mode_q (oneshot/periodic). Set count<=0, pre<=0, periods<=0, state<=LOAD.
  - STOP: state<=IDLE; count, periods and config are held.
  - CLEAR: state<=IDLE; count<=0, periods<=0.
- LOAD always goes to RUN at the next edge (E1). No commands are accepted in LOAD.
- RUN, every edge:
  - If pre==div_q: pre<=0 and a tick occurs. Otherwise pre<=pre+1 with no tick.
  - Tick with count!=limit_q: count<=count+1.
  - Tick with count==limit_q: tc_pulse<=1 for one cycle, and periods<=periods+1 (saturating).
    - Periodic mode: count<=0, stay in RUN.
    - One-shot mode: count holds at limit_q, state<=DONE.
- tc_pulse is 0 on every edge where the terminal condition is not met.
- Latency: with div=0 the first increment lands at E2. With limit=L and div=D, the first tc_pulse is high in the cycle after edge E1 + (L+1)(D+1).
- Boundaries:
  - limit=0: tc_pulse on every tick; count stays 0.
  - div=0: a tick every RUN cycle.
  - count never exceeds limit_q. A wrap at 2^WIDTH-1 occurs only when limit is all-ones.
  - periods saturates at all-ones and does not wrap.
- Simultaneous events:
  - A command accepted in RUN on the same edge as a tick wins. The tick is discarded, with no tc_pulse and no periods increment.
  - A START accepted in DONE restarts normally. done drops at that edge.
- DONE holds count and periods until a command is accepted.

Decomposition:
- Shared package counter_ctrl_pkg holds:
  - opcode localparams OP_STOP, OP_START_ONESHOT, OP_START_PERIODIC, OP_CLEAR;
  - the state encoding (IDLE=0, LOAD=1, RUN=2, DONE=3);
  - mode bit constants.
- One sub-module, counter_prescaler, holds the pre counter.
  - Inputs: clk, rst, clr, en, div.
  - Output: tick.
  - tick = en && pre==div.
  - Resets and clears pre to 0.

Test Plan:
- Reset mid-RUN: assert rst while count=2 -> count=0, state IDLE, cmd_ready=1, busy=0, no tc_pulse.
- START_ONESHOT, limit=3, div=0:
  - count goes 0,1,2,3 across E1..E4;
  - tc_pulse=1 for exactly one cycle after E5;
  - done=1 with count held at 3;
  - periods=1.
- START_PERIODIC, limit=2, div=1:
  - count increments every 2 cycles through 0,1,2,0;
  - tc_pulse every 6 cycles;
  - after 300 periods, periods=255 (saturated).
- Handshake: cmd_valid held high across START -> cmd_ready=0 exactly one cycle (LOAD), then 1. A second START is accepted at the next edge and restarts count at 0.
- Collision: STOP issued on the tick edge where count==limit (periodic, limit=1) -> no tc_pulse, periods unchanged, state IDLE, count held at 1.
- CLEAR from DONE after a one-shot with limit=0 -> count=0, periods=0, done=0, idle.
